// File: rtl/filter_sel_ctrl_pkg.sv
// Shared types and constants for the filter mode-switch sequencer.
package filter_ctrl_pkg;

   localparam int GAIN_W     = 5;
   localparam int GAIN_MAX   = 16;
   localparam int GAIN_SHIFT = 4;
   localparam int SEL_W      = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FADE_OUT = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_FADE_IN  = 2'd3
   } state_t;

   typedef logic [SEL_W-1:0] sel_t;

   typedef struct packed {
      logic valid;
      sel_t sel;
   } mode_req_t;

endpackage

// File: rtl/filter_sel_ctrl_if.sv
// Request channel plus filter-side and audio-side signals of the sequencer.
interface filter_sel_ctrl_if #(
   parameter int BIT_WIDTH = 24
) ();
   import filter_ctrl_pkg::*;

   logic                 sample_en;
   logic                 req_valid;
   sel_t                 req_sel;
   logic                 req_ready;
   logic [BIT_WIDTH-1:0] filt_q;
   sel_t                 filt_sel;
   logic                 filt_reset_n;
   logic [BIT_WIDTH-1:0] audio_out;
   logic                 busy;

   modport master (
      output sample_en, req_valid, req_sel, filt_q,
      input  req_ready, filt_sel, filt_reset_n, audio_out, busy
   );

   modport slave (
      input  sample_en, req_valid, req_sel, filt_q,
      output req_ready, filt_sel, filt_reset_n, audio_out, busy
   );
endinterface

// File: rtl/filter_sel_ctrl_fade_gain.sv
// Registered signed gain stage: audio = floor(q * gain / 16), updated on sample_en.
module fade_gain
   import filter_ctrl_pkg::*;
#(
   parameter int BIT_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_sample_en,
   input  logic [GAIN_W-1:0]    i_gain,
   input  logic [BIT_WIDTH-1:0] i_q,
   output logic [BIT_WIDTH-1:0] o_audio
);
   // Product wide enough for q times a 0..16 gain plus sign.
   localparam int P_W = BIT_WIDTH + GAIN_W + 1;

   logic signed [P_W-1:0] w_q_ext;
   logic signed [P_W-1:0] w_g_ext;
   logic signed [P_W-1:0] w_prod;
   logic [BIT_WIDTH-1:0]  r_audio;

   assign w_q_ext = {{(P_W-BIT_WIDTH){i_q[BIT_WIDTH-1]}}, i_q};
   assign w_g_ext = {{(P_W-GAIN_W){1'b0}}, i_gain};
   assign w_prod  = w_q_ext * w_g_ext;
   assign o_audio = r_audio;

   // Arithmetic shift floors toward -inf; gain 16 reproduces the input exactly.
   always_ff @(posedge clk) begin
      if (!reset_n)         r_audio <= '0;
      else if (i_sample_en) r_audio <= BIT_WIDTH'(w_prod >>> GAIN_SHIFT);
   end
endmodule

// File: rtl/filter_sel_ctrl.sv
// Click-free filter mode switch: fade out, swap filt_sel, flush delay line, fade in.
module filter_sel_ctrl
   import filter_ctrl_pkg::*;
#(
   parameter int BIT_WIDTH     = 24,
   parameter int FLUSH_SAMPLES = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   filter_sel_ctrl_if.slave   bus
);
   localparam int CNT_W = $clog2(FLUSH_SAMPLES + 1);

   state_t              r_state, w_nxt_state;
   logic [GAIN_W-1:0]   r_gain, w_nxt_gain;
   logic [CNT_W-1:0]    r_cnt, w_nxt_cnt, w_cnt_inc;
   sel_t                r_pend, w_nxt_pend, w_pend_new;
   sel_t                r_filt_sel, w_nxt_filt_sel;
   logic                r_filt_rst_n, w_nxt_filt_rst_n;
   logic                r_req_ready, w_nxt_req_ready;
   logic                r_busy, w_nxt_busy;
   logic                w_accept;
   logic                w_se;
   mode_req_t           w_req;
   logic [BIT_WIDTH-1:0] w_audio;

   assign w_req      = {bus.req_valid, bus.req_sel};
   assign w_se       = bus.sample_en;
   assign w_accept   = w_req.valid && r_req_ready;
   // Latest accepted request wins, even on the sample where the fade bottoms out.
   assign w_pend_new = w_accept ? w_req.sel : r_pend;
   assign w_cnt_inc  = r_cnt + CNT_W'(1);

   // State and all registered outputs; reset lands in FLUSH so power-up fades in.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= ST_FLUSH;
         r_gain       <= '0;
         r_cnt        <= '0;
         r_pend       <= '0;
         r_filt_sel   <= '0;
         r_filt_rst_n <= 1'b0;
         r_req_ready  <= 1'b0;
         r_busy       <= 1'b1;
      end else begin
         r_state      <= w_nxt_state;
         r_gain       <= w_nxt_gain;
         r_cnt        <= w_nxt_cnt;
         r_pend       <= w_nxt_pend;
         r_filt_sel   <= w_nxt_filt_sel;
         r_filt_rst_n <= w_nxt_filt_rst_n;
         r_req_ready  <= w_nxt_req_ready;
         r_busy       <= w_nxt_busy;
      end
   end

   // Next-state: fades and flush advance only on sample_en.
   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         ST_IDLE:     if (w_accept && (w_req.sel != r_filt_sel)) w_nxt_state = ST_FADE_OUT;
         ST_FADE_OUT: if (w_se && (r_gain == GAIN_W'(1))) w_nxt_state = ST_FLUSH;
         ST_FLUSH:    if (w_se && r_filt_rst_n && (w_cnt_inc == CNT_W'(FLUSH_SAMPLES)))
                         w_nxt_state = ST_FADE_IN;
         ST_FADE_IN:  if (w_se && (r_gain == GAIN_W'(GAIN_MAX - 1))) w_nxt_state = ST_IDLE;
         default:     w_nxt_state = ST_FLUSH;
      endcase
   end

   // Next values of gain, counter, pending mode and filter controls.
   always_comb begin
      w_nxt_gain       = r_gain;
      w_nxt_cnt        = r_cnt;
      w_nxt_pend       = r_pend;
      w_nxt_filt_sel   = r_filt_sel;
      w_nxt_filt_rst_n = r_filt_rst_n;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && (w_req.sel != r_filt_sel)) w_nxt_pend = w_req.sel;
         end
         ST_FADE_OUT: begin
            w_nxt_pend = w_pend_new;
            if (w_se) begin
               w_nxt_gain = r_gain - GAIN_W'(1);
               if (r_gain == GAIN_W'(1)) begin
                  w_nxt_filt_sel   = w_pend_new;
                  w_nxt_filt_rst_n = 1'b0;
                  w_nxt_cnt        = '0;
               end
            end
         end
         ST_FLUSH: begin
            // First sample only releases the filter clear; later ones count.
            if (w_se) begin
               if (!r_filt_rst_n) w_nxt_filt_rst_n = 1'b1;
               else               w_nxt_cnt        = w_cnt_inc;
            end
         end
         ST_FADE_IN: begin
            if (w_se) w_nxt_gain = r_gain + GAIN_W'(1);
         end
         default: ;
      endcase
      w_nxt_req_ready = (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_FADE_OUT);
      w_nxt_busy      = (w_nxt_state != ST_IDLE);
   end

   fade_gain #(.BIT_WIDTH(BIT_WIDTH)) u_gain (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_sample_en(w_se),
      .i_gain     (r_gain),
      .i_q        (bus.filt_q),
      .o_audio    (w_audio)
   );

   assign bus.audio_out    = w_audio;
   assign bus.filt_sel     = r_filt_sel;
   assign bus.filt_reset_n = r_filt_rst_n;
   assign bus.req_ready    = r_req_ready;
   assign bus.busy         = r_busy;
endmodule

// File: tb/tb_filter_sel_ctrl.sv
// Bench for filter_sel_ctrl: timeline reference model, directed steps plus random traffic.
module tb_filter_sel_ctrl;
   localparam int BW      = 24;
   localparam int T_FLUSH = 16;   // samples after accept when FLUSH begins
   localparam int T_IDLE  = 49;   // samples after accept when back to IDLE

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   filter_sel_ctrl_if #(.BIT_WIDTH(BW)) bus ();

   filter_sel_ctrl #(.BIT_WIDTH(BW), .FLUSH_SAMPLES(16)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Model: one number, samples elapsed since the switch was accepted.
   int          m_t;
   logic [2:0]  m_sel, m_pend;
   logic [BW-1:0] m_audio;
   bit          rnd_q;

   function automatic int gain_of(input int t);
      if (t <= 16)      return 16 - t;
      else if (t <= 33) return 0;
      else              return t - 33;
   endfunction

   function automatic logic [BW-1:0] scale(input logic [BW-1:0] q, input int g);
      longint p;
      p = longint'($signed(q)) * longint'(g);
      p = p >>> 4;
      return p[BW-1:0];
   endfunction

   task automatic model_edge();
      int g;
      bit rdy;
      if (!reset_n) begin
         m_t = T_FLUSH; m_sel = '0; m_pend = '0; m_audio = '0;
         return;
      end
      g   = gain_of(m_t);
      rdy = (m_t < T_FLUSH) || (m_t >= T_IDLE);
      if (bus.sample_en) m_audio = scale(bus.filt_q, g);
      if (m_t >= T_IDLE) begin
         if (bus.req_valid && rdy && (bus.req_sel != m_sel)) begin
            m_pend = bus.req_sel;
            m_t = 0;
         end
      end else begin
         if (bus.req_valid && rdy) m_pend = bus.req_sel;
         if (bus.sample_en) begin
            m_t++;
            if (m_t == T_FLUSH) m_sel = m_pend;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic step();
      if (rnd_q) bus.filt_q = BW'($urandom);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("audio_out", 32'(bus.audio_out), 32'(m_audio));
      chk("filt_sel", 32'(bus.filt_sel), 32'(m_sel));
      chk("filt_reset_n", 32'(bus.filt_reset_n), 32'(m_t != T_FLUSH));
      chk("req_ready", 32'(bus.req_ready), 32'((m_t < T_FLUSH) || (m_t >= T_IDLE)));
      chk("busy", 32'(bus.busy), 32'(m_t < T_IDLE));
   endtask

   task automatic request(input logic [2:0] sel);
      bus.req_valid = 1'b1;
      bus.req_sel   = sel;
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic run_to_idle(input int budget);
      for (int i = 0; i < budget && m_t < T_IDLE; i++) step();
      chk("reach_idle", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int n_busy;
      int guard;
      logic [2:0] sel_at_flush;
      logic [BW-1:0] frozen;

      bus.sample_en = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_sel   = '0;
      bus.filt_q    = 24'h100000;
      rnd_q         = 1'b0;
      m_t = T_FLUSH; m_sel = '0; m_pend = '0; m_audio = '0;

      // Reset state.
      reset_n = 1'b0;
      step(); step();

      // Power-up: 1 reset sample, 16 flush, 16 fade-in with constant input.
      reset_n = 1'b1;
      for (int i = 0; i < 36; i++) step();
      chk("powerup_unity", 32'(bus.audio_out), 32'h100000);
      chk("powerup_ready", 32'(bus.req_ready), 32'd1);

      // Full switch to mode 3 with random samples; busy must span 49 samples.
      rnd_q = 1'b1;
      n_busy = 0;
      sel_at_flush = '0;
      request(3'd3);
      if (bus.busy) n_busy++;
      for (int i = 0; i < 60; i++) begin
         step();
         if (bus.busy) n_busy++;
         if (!bus.filt_reset_n) sel_at_flush = bus.filt_sel;
      end
      chk("busy_len", 32'(n_busy), 32'd49);
      chk("flush_sel", 32'(sel_at_flush), 32'd3);

      // Retargeting during fade-out; request during flush must be refused.
      request(3'd1);
      guard = 0;
      while (gain_of(m_t) != 10 && guard < 20) begin step(); guard++; end
      request(3'd5);
      guard = 0;
      while (gain_of(m_t) != 7 && guard < 20) begin step(); guard++; end
      request(3'd6);
      guard = 0;
      while (m_t < 20 && guard < 20) begin step(); guard++; end
      bus.req_valid = 1'b1; bus.req_sel = 3'd2;
      step(); step(); step();
      bus.req_valid = 1'b0;
      run_to_idle(60);
      chk("latest_wins", 32'(bus.filt_sel), 32'd6);

      // Same-mode request is a no-op.
      request(3'd6);
      for (int i = 0; i < 4; i++) step();
      chk("same_sel_busy", 32'(bus.busy), 32'd0);

      // Negative sample floors; sample_en low freezes the fade.
      rnd_q = 1'b0;
      bus.filt_q = 24'hFFFFEF;
      request(3'd4);
      guard = 0;
      while (gain_of(m_t) != 8 && guard < 20) begin step(); guard++; end
      step();
      chk("neg_floor", 32'(bus.audio_out), 32'hFFFFF7);
      rnd_q = 1'b1;
      guard = 0;
      while (m_t < 40 && guard < 60) begin step(); guard++; end
      frozen = m_audio;
      bus.sample_en = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("freeze_audio", 32'(bus.audio_out), 32'(frozen));
      bus.sample_en = 1'b1;
      run_to_idle(60);

      // Random traffic: sporadic sample_en, requests only on sample strobes.
      for (int i = 0; i < 300; i++) begin
         bus.sample_en = ($urandom_range(3) != 0);
         bus.req_valid = bus.sample_en && ($urandom_range(5) == 0);
         bus.req_sel   = 3'($urandom);
         step();
      end
      bus.sample_en = 1'b1;
      bus.req_valid = 1'b0;
      run_to_idle(120);

      // Reset mid-fade-out discards the pending mode.
      request(m_sel + 3'd1);
      for (int i = 0; i < 5; i++) step();
      reset_n = 1'b0;
      step();
      chk("rst_sel", 32'(bus.filt_sel), 32'd0);
      chk("rst_clear", 32'(bus.filt_reset_n), 32'd0);
      chk("rst_audio", 32'(bus.audio_out), 32'd0);
      reset_n = 1'b1;
      run_to_idle(60);
      chk("pend_dropped", 32'(bus.filt_sel), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/filter_sel_ctrl.md
# filter_sel_ctrl

Sequencer that owns the `filt_sel` input of the 16-tap FIR low-pass filter and changes filter mode without clicks. On each mode request it ramps output gain down to zero, switches `filt_sel`, clears and refills the filter delay line, then ramps gain back to unity. It sits between the front-panel/register mode request and the filter, and its gained output drives the downstream audio path.

## Interface
- `BIT_WIDTH`, 24: sample width, signed two's complement.
- `FLUSH_SAMPLES`, 16: samples to wait after clearing the delay line; must be ≥ filter tap count.
- `clk`  in  1: system clock.
- `reset_n`  in  1: reset, synchronous, active-low.
- `sample_en`  in  1: one-cycle strobe per audio sample; all state advances only on `sample_en`.
- `req_valid`  in  1: mode-change request.
- `req_sel`  in  3: requested filter mode.
- `req_ready`  out  1: request accepted when `req_valid && req_ready`.
- `filt_q`  in  BIT_WIDTH: filter output sample.
- `filt_sel`  out  3: mode driven to the filter.
- `filt_reset_n`  out  1: synchronous clear driven to the filter.
- `audio_out`  out  BIT_WIDTH: gained filter output.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- States: IDLE, FADE_OUT, FLUSH, FADE_IN. Reset state is FLUSH, so power-up fades in from silence.
- Reset values: `filt_sel`=0, gain=0, `filt_reset_n`=0, `audio_out`=0, `req_ready`=0, `busy`=1, flush counter=0, pending=0.
- Gain: 5-bit unsigned, 0..16, where 16 is unity.
  - `audio_out` = (`filt_q` × gain) >>> 4.
  - Use a signed product of BIT_WIDTH+6 bits, arithmetic shift (floor), truncated to BIT_WIDTH. Gain 16 gives exact passthrough.
- `req_ready`=1 in IDLE and FADE_OUT, 0 in FLUSH and FADE_IN.
- IDLE, on accept:
  - If `req_sel` == `filt_sel`, no-op and stay in IDLE.
  - Otherwise store pending=`req_sel` and go to FADE_OUT.
- FADE_OUT:
  - An accepted request overwrites pending; the latest request wins.
  - Each `sample_en` decrements gain by 1.
  - On the `sample_en` where gain becomes 0: set `filt_sel`←pending and `filt_reset_n`←0, counter←0, go to FLUSH.
  - If pending == `filt_sel` when gain hits 0, FLUSH still runs.
- FLUSH:
  - The first `sample_en` releases `filt_reset_n`←1. This holds `filt_reset_n` low through at least one filter clock edge.
  - Each later `sample_en` increments the counter. When it reaches FLUSH_SAMPLES, go to FADE_IN.
  - Gain stays at 0.
- FADE_IN:
  - Each `sample_en` increments gain by 1.
  - On the `sample_en` where gain reaches 16, go to IDLE.
- With `sample_en` low, state, gain, counter and `audio_out` hold.
- Reset asserted in any state returns to the reset values on the next `clk` edge; any pending request is discarded.

## Timing
- `audio_out` is registered on `sample_en` using that cycle's `filt_q` and the gain value before that cycle's update. Latency is 1 clk.
- `filt_sel`, `filt_reset_n`, `busy` and `req_ready` are registered and change the cycle after the triggering edge.
- Full switch from IDLE, with `sample_en` every cycle:
  - 16 FADE_OUT samples.
  - 1 reset sample plus FLUSH_SAMPLES flush samples.
  - 16 FADE_IN samples.
  - Total 49 samples at the defaults; `busy` is high throughout.

## Structure
- Package `filter_ctrl_pkg` holds:
  - state enum;
  - `GAIN_W`=5, `GAIN_MAX`=16, `GAIN_SHIFT`=4;
  - `SEL_W`=3.
- One natural sub-module: `fade_gain`, the registered signed multiply-and-shift with `sample_en` enable.
- The FSM, counter and pending register stay in the top level.

## Test plan
- Reset release, `sample_en`=1 every cycle, `filt_q`=0x100000:
  - `filt_reset_n` is low 1 sample, then 16 flush samples with `audio_out`=0.
  - `audio_out` then steps 0x000000, 0x010000 … 0x0F0000, reaching 0x100000 one sample after gain reaches 16.
  - `req_ready` is then 1.
- IDLE, `req_sel`=3:
  - `audio_out` ramps 0x100000→0x010000→0.
  - `filt_sel` becomes 3 with `filt_reset_n`=0 at FLUSH entry.
  - Fade-in follows; total `busy` 49 samples.
- `req_sel`=5 in FADE_OUT at gain 10, then `req_sel`=6 at gain 7:
  - `filt_sel` becomes 6 at FLUSH.
  - During FLUSH, `req_valid` with `req_sel`=2 sees `req_ready`=0 and is not accepted.
- `req_sel` equal to the current `filt_sel` in IDLE: `busy` stays 0 and no outputs change.
- `filt_q`=-17 (0xFFFFEF) at gain 8: `audio_out`=-9 (0xFFFFF7). Also, `sample_en` held low for 10 cycles mid-FADE_IN freezes gain and `audio_out`.
- `reset_n` low for 1 cycle mid-FADE_OUT: next cycle `filt_sel`=0, gain=0, `filt_reset_n`=0, state FLUSH; pending is discarded.
